alu_md: RTL and testbench

- Parametrised successor to the core integer ALU. WIDTH-bit ALU with registered result, plus an iterative multiply/divide engine and HI/LO registers.
- Sits in the EX stage. The hazard unit stalls the pipeline on `busy`.
- Single-cycle ops complete in 1 cycle. MULT/DIV take WIDTH+1 cycles.

---
 rtl/alu_md.sv | 199 +++++++++++++++++++
 tb/tb_alu_md.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// alu_md: registered integer ALU with an iterative shift-add multiplier and restoring
// divider that write the HI/LO pair; multi-cycle ops hold busy until their FIN cycle.
module alu_md #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             ovf_en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             div0,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MFHI = 4'b1100;
  localparam logic [3:0] OP_MFLO = 4'b1101;
  localparam logic [3:0] OP_MTHI = 4'b1110;
  localparam logic [3:0] OP_MTLO = 4'b1111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, hi_q, lo_q, opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;
  logic               negRes_q, negRem_q, overflow_q, div0_q, done_q;

  logic             accept, isMul, isDiv, signedOp, lastIter, divByZero;
  logic [WIDTH-1:0] magA, magB, sum, diff, aluOut;
  logic             aluOvf;

  assign accept    = start && (state_q == IDLE);
  assign isMul     = (op[3:1] == 3'b100);
  assign isDiv     = (op[3:1] == 3'b101);
  assign signedOp  = ~op[0];
  assign lastIter  = (cnt_q == '0);
  assign divByZero = (opnd_q == '0);
  assign magA      = (signedOp && a[WIDTH-1]) ? (~a + ONE) : a;
  assign magB      = (signedOp && b[WIDTH-1]) ? (~b + ONE) : b;
  assign sum       = a + b;
  assign diff      = a + ~b + ONE;

  always_comb begin
    aluOut = '0;
    aluOvf = 1'b0;
    case (op)
      OP_AND:  aluOut = a & b;
      OP_OR:   aluOut = a | b;
      OP_XOR:  aluOut = a ^ b;
      OP_NOR:  aluOut = ~(a | b);
      OP_ADD: begin
        aluOut = sum;
        aluOvf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        aluOut = diff;
        aluOvf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLT:  aluOut = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: aluOut = {{(WIDTH-1){1'b0}}, a < b};
      OP_MFHI: aluOut = hi_q;
      OP_MFLO: aluOut = lo_q;
      OP_MTHI, OP_MTLO: aluOut = a;
      default: aluOut = '0;
    endcase
  end

  // acc_q holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  logic [WIDTH-1:0]   addend, divRem, quoFinal, remFinal, dzHi;
  logic [WIDTH:0]     mulSum, divTrial;
  logic [2*WIDTH-1:0] mulNext, divNext, mulFinal;
  logic               divGe;

  assign addend   = acc_q[0] ? opnd_q : '0;
  assign mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign mulNext  = {mulSum, acc_q[WIDTH-1:1]};
  assign divTrial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign divGe    = divTrial >= {1'b0, opnd_q};
  assign divRem   = divGe ? (divTrial[WIDTH-1:0] - opnd_q) : divTrial[WIDTH-1:0];
  assign divNext  = {divRem, acc_q[WIDTH-2:0], divGe};
  assign mulFinal = negRes_q ? -mulNext : mulNext;
  assign quoFinal = negRes_q ? -divNext[WIDTH-1:0] : divNext[WIDTH-1:0];
  assign remFinal = negRem_q ? -divNext[2*WIDTH-1:WIDTH] : divNext[2*WIDTH-1:WIDTH];
  assign dzHi     = negRem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && isMul)      state_d = MUL;
        else if (accept && isDiv) state_d = DIV;
      end
      MUL:     if (lastIter) state_d = FIN;
      DIV:     if (divByZero || lastIter) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    done     = done_q;
    result   = result_q;
    zero     = (result_q == '0);
    overflow = overflow_q;
    div0     = div0_q;
  end

  // Final signed HI/LO are written on the last iteration edge so they are valid during FIN
  always_ff @(posedge clk) begin
    if (reset) begin
      result_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      negRes_q   <= 1'b0;
      negRem_q   <= 1'b0;
      overflow_q <= 1'b0;
      div0_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && (isMul || isDiv)) begin
            acc_q    <= {{WIDTH{1'b0}}, magA};
            opnd_q   <= magB;
            negRes_q <= signedOp && (a[WIDTH-1] ^ b[WIDTH-1]);
            negRem_q <= signedOp && a[WIDTH-1];
            cnt_q    <= CW'(WIDTH - 1);
            if (isDiv) div0_q <= (b == '0);
          end else if (accept) begin
            result_q   <= aluOut;
            overflow_q <= ovf_en && aluOvf;
            done_q     <= 1'b1;
            if (op == OP_MTHI) hi_q <= a;
            if (op == OP_MTLO) lo_q <= a;
          end
        end
        MUL: begin
          acc_q <= mulNext;
          cnt_q <= cnt_q - CW'(1);
          if (lastIter) begin
            hi_q       <= mulFinal[2*WIDTH-1:WIDTH];
            lo_q       <= mulFinal[WIDTH-1:0];
            result_q   <= mulFinal[WIDTH-1:0];
            overflow_q <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        DIV: begin
          if (divByZero) begin
            hi_q       <= dzHi;
            lo_q       <= '1;
            result_q   <= '1;
            overflow_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            acc_q <= divNext;
            cnt_q <= cnt_q - CW'(1);
            if (lastIter) begin
              hi_q       <= remFinal;
              lo_q       <= quoFinal;
              result_q   <= quoFinal;
              overflow_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: scoreboard bench for alu_md at WIDTH=32; a behavioural model pushes the
// expected completion when each op is driven and it is popped when done arrives.
module tb_alu_md;

  localparam int W = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_MULTU= 4'b1001;
  localparam logic [3:0] OP_DIV  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_MFHI = 4'b1100;
  localparam logic [3:0] OP_MFLO = 4'b1101;
  localparam logic [3:0] OP_MTHI = 4'b1110;
  localparam logic [3:0] OP_MTLO = 4'b1111;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         ovfEn = 1'b0;
  logic [3:0]   op = 4'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;
  logic         zero, overflow, div0, busy, done;

  always #5 clk = ~clk;

  alu_md #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .ovf_en(ovfEn),
    .a(a), .b(b), .result(result), .zero(zero), .overflow(overflow),
    .div0(div0), .busy(busy), .done(done)
  );

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        dz;
    int          lat;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;
  logic        mDiv0 = 1'b0;
  int          checks = 0;
  int          passes = 0;

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                 input logic en, input string tag);
    exp_t        e;
    longint      sx, sy, s;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.tag = tag; e.lat = 1; e.ovf = 1'b0; e.res = '0;
    case (o)
      OP_AND:  e.res = x & y;
      OP_OR:   e.res = x | y;
      OP_XOR:  e.res = x ^ y;
      OP_NOR:  e.res = ~(x | y);
      OP_ADD, OP_SUB: begin
        s = (o == OP_ADD) ? sx + sy : sx - sy;
        e.res = s[31:0];
        e.ovf = en && (s > 64'sd2147483647 || s < -64'sd2147483648);
      end
      OP_SLT:  e.res = (sx < sy) ? 32'd1 : 32'd0;
      OP_SLTU: e.res = (x < y) ? 32'd1 : 32'd0;
      OP_MULT, OP_MULTU: begin
        if (o == OP_MULT) p = sx * sy;
        else              p = {32'b0, x} * {32'b0, y};
        mHi = p[63:32]; mLo = p[31:0]; e.res = mLo; e.lat = 33;
      end
      OP_DIV, OP_DIVU: begin
        mDiv0 = (y == 32'd0);
        e.lat = 33;
        if (y == 32'd0) begin
          mHi = x; mLo = 32'hFFFF_FFFF; e.lat = 2;
        end else if (o == OP_DIV && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          mLo = 32'h8000_0000; mHi = 32'd0;
        end else if (o == OP_DIV) begin
          mLo = 32'(sx / sy); mHi = 32'(sx % sy);
        end else begin
          mLo = x / y; mHi = x % y;
        end
        e.res = mLo;
      end
      OP_MFHI: e.res = mHi;
      OP_MFLO: e.res = mLo;
      OP_MTHI: begin mHi = x; e.res = x; end
      OP_MTLO: begin mLo = x; e.res = x; end
      default: e.res = '0;
    endcase
    e.dz = mDiv0;
    return e;
  endfunction

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic en, input string tag);
    sb.push_back(model(o, x, y, en, tag));
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; ovfEn = en;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(output int k);
    k = 1;
    while (done !== 1'b1 && k < 200) begin
      @(posedge clk);
      #1 k++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (result !== 32'd0) $display("[TB] FAIL reset result: got %h want 0", result); else passes++;
    checks++; if (zero !== 1'b1) $display("[TB] FAIL reset zero: got %b want 1", zero); else passes++;
    checks++; if ({overflow, div0, busy, done} !== 4'b0000)
      $display("[TB] FAIL reset flags: got ovf/div0/busy/done=%b%b%b%b want 0000", overflow, div0, busy, done);
    else passes++;
    reset = 1'b0;
    mHi = '0; mLo = '0; mDiv0 = 1'b0;
  endtask

  task automatic test_alu();
    logic [3:0]  tOp[13] = '{OP_ADD, OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_SUB, OP_ADD,
                             OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SUB, OP_ADD};
    logic [31:0] tA[13]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'h8000_0000, 32'hF0F0_1234, 32'hF0F0_1234,
                             32'hF0F0_1234, 32'hF0F0_1234, 32'd3, 32'hFFFF_FFFF};
    logic [31:0] tB[13]  = '{32'd1, 32'd1, 32'd5, 32'd1, 32'd1, 32'd1, 32'h8000_0000,
                             32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00, 32'h0FF0_FF00,
                             32'd5, 32'd1};
    logic        tEn[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                             1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_t e;
    int   k;
    for (int i = 0; i < 13; i++) begin
      issue(tOp[i], tA[i], tB[i], tEn[i], $sformatf("alu%0d", i));
      waitDone(k);
      e = sb.pop_front();
      checks++; if (k !== e.lat || done !== 1'b1)
        $display("[TB] FAIL %s latency: got %0d cycles done=%b want %0d", e.tag, k, done, e.lat);
      else passes++;
      checks++; if (result !== e.res) $display("[TB] FAIL %s result: got %h want %h", e.tag, result, e.res); else passes++;
      checks++; if (overflow !== e.ovf) $display("[TB] FAIL %s overflow: got %b want %b", e.tag, overflow, e.ovf); else passes++;
      checks++; if (zero !== (e.res == 32'd0)) $display("[TB] FAIL %s zero: got %b want %b", e.tag, zero, e.res == 32'd0); else passes++;
    end
  endtask

  task automatic test_muldiv();
    logic [3:0]  qOp[$] = '{OP_MULT, OP_MFHI, OP_MFLO, OP_MULTU, OP_MFHI, OP_MFLO,
                            OP_DIV, OP_MFHI, OP_DIVU, OP_MFHI, OP_DIV, OP_MFHI,
                            OP_DIVU, OP_MFHI, OP_DIV, OP_MFHI, OP_MULT, OP_MFHI};
    logic [31:0] qA[$]  = '{32'hFFFF_FFFD, 0, 0, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFF9, 0,
                            32'd7, 0, 32'h8000_0000, 0, 32'd100, 0, 32'd7, 0,
                            32'h8000_0000, 0};
    logic [31:0] qB[$]  = '{32'd5, 0, 0, 32'hFFFF_FFFF, 0, 0, 32'd2, 0, 32'd0, 0,
                            32'hFFFF_FFFF, 0, 32'd7, 0, 32'hFFFF_FFFE, 0,
                            32'h8000_0000, 0};
    exp_t e;
    int   k;
    for (int i = 0; i < 4; i++) begin
      qOp.push_back(4'b1000 | 4'($urandom_range(0, 3)));
      qA.push_back($urandom);
      qB.push_back($urandom);
      qOp.push_back(OP_MFHI); qA.push_back(0); qB.push_back(0);
    end
    foreach (qOp[i]) begin
      issue(qOp[i], qA[i], qB[i], 1'b1, $sformatf("md%0d", i));
      waitDone(k);
      e = sb.pop_front();
      checks++; if (k !== e.lat || done !== 1'b1)
        $display("[TB] FAIL %s latency: got %0d cycles done=%b want %0d", e.tag, k, done, e.lat);
      else passes++;
      checks++; if (result !== e.res) $display("[TB] FAIL %s result: got %h want %h", e.tag, result, e.res); else passes++;
      checks++; if (overflow !== e.ovf) $display("[TB] FAIL %s overflow: got %b want %b", e.tag, overflow, e.ovf); else passes++;
      checks++; if (div0 !== e.dz) $display("[TB] FAIL %s div0: got %b want %b", e.tag, div0, e.dz); else passes++;
      if (e.lat > 1) begin
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0)
          $display("[TB] FAIL %s release: got busy=%b done=%b want 0 0", e.tag, busy, done);
        else passes++;
      end
    end
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int   k, busyLost;
    issue(OP_MULT, 32'h0001_2345, 32'hFFFF_F889, 1'b0, "busyMult");
    k = 1; busyLost = 0;
    while (done !== 1'b1 && k < 200) begin
      if (busy !== 1'b1) busyLost++;
      if (k == 5) begin
        start = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd2;
        @(posedge clk);
        #1 start = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
      k++;
    end
    e = sb.pop_front();
    checks++; if (k !== 33 || done !== 1'b1) $display("[TB] FAIL busyMult latency: got %0d done=%b want 33", k, done); else passes++;
    checks++; if (result !== e.res) $display("[TB] FAIL busyMult result: got %h want %h", result, e.res); else passes++;
    checks++; if (busyLost !== 0) $display("[TB] FAIL busyMult busy: dropped %0d cycles want 0", busyLost); else passes++;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL busyMult release: got busy=%b want 0", busy); else passes++;
    issue(OP_MFHI, 0, 0, 1'b0, "busyHi");
    waitDone(k);
    e = sb.pop_front();
    checks++; if (result !== e.res || k !== 1) $display("[TB] FAIL busyHi result: got %h in %0d want %h in 1", result, k, e.res); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  tOp[6] = '{OP_ADD, OP_SUB, OP_MTHI, OP_MFHI, OP_XOR, OP_SLT};
    logic [31:0] tA[6]  = '{32'd1, 32'd10, 32'h0000_CAFE, 32'd0, 32'hAAAA_5555, 32'd5};
    logic [31:0] tB[6]  = '{32'd2, 32'd3, 32'd0, 32'd0, 32'hFFFF_0000, 32'hFFFF_FFFB};
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b1; op = tOp[i]; a = tA[i]; b = tB[i]; ovfEn = 1'b1;
      sb.push_back(model(tOp[i], tA[i], tB[i], 1'b1, $sformatf("b2b%0d", i)));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++; if (done !== 1'b1) $display("[TB] FAIL %s done: got %b want 1", e.tag, done); else passes++;
      checks++; if (result !== e.res) $display("[TB] FAIL %s result: got %h want %h", e.tag, result, e.res); else passes++;
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) $display("[TB] FAIL b2b pulse: got done=%b want 0", done); else passes++;
  endtask

  task automatic test_reset_abort();
    logic [3:0]  tOp[5] = '{OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO, OP_ADD};
    logic [31:0] tA[5]  = '{32'h0000_1234, 32'h0000_5678, 0, 0, 32'd20};
    logic [31:0] tB[5]  = '{0, 0, 0, 0, 32'd22};
    exp_t e;
    int   k;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        @(negedge clk);
        start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) $display("[TB] FAIL abort running: got busy=%b want 1", busy); else passes++;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        mHi = '0; mLo = '0; mDiv0 = 1'b0;
        checks++; if ({busy, done} !== 2'b00) $display("[TB] FAIL abort flags: got busy/done=%b%b want 00", busy, done); else passes++;
        checks++; if (result !== 32'd0 || zero !== 1'b1) $display("[TB] FAIL abort result: got %h zero=%b want 0 1", result, zero); else passes++;
      end
      issue(tOp[i], tA[i], tB[i], 1'b1, $sformatf("abort%0d", i));
      waitDone(k);
      e = sb.pop_front();
      checks++; if (k !== 1 || done !== 1'b1) $display("[TB] FAIL %s latency: got %0d done=%b want 1", e.tag, k, done); else passes++;
      checks++; if (result !== e.res) $display("[TB] FAIL %s result: got %h want %h", e.tag, result, e.res); else passes++;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_alu();
    test_muldiv();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
